// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse pattern generator: FSM states,
// Morse timing units and the character code enumeration.
package morse_pkg;

  localparam int CODE_MAX   = 35;
  localparam int DOT_UNITS  = 1;
  localparam int DASH_UNITS = 3;
  localparam int GAP_UNITS  = 1;
  localparam int MAX_UNITS  = 19;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT_ON  = 2'd1,
    ST_EMIT_GAP = 2'd2,
    ST_COMMIT   = 2'd3
  } state_e;

  // Letters occupy 0-25, digits 26-35; anything above CODE_MAX is invalid.
  typedef enum logic [5:0] {
    CH_A = 6'd0, CH_B, CH_C, CH_D, CH_E, CH_F, CH_G, CH_H, CH_I, CH_J,
    CH_K, CH_L, CH_M, CH_N, CH_O, CH_P, CH_Q, CH_R, CH_S, CH_T,
    CH_U, CH_V, CH_W, CH_X, CH_Y, CH_Z,
    CH_0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7, CH_8, CH_9
  } char_code_e;

endpackage

// File: rtl/morse_pattern_gen_if.sv
// Request/result bundle between the requester (master) and the pattern
// generator (slave).
interface morse_pattern_gen_if #(
  parameter int PATTERN_W = 75
);
  logic                 start;
  logic [5:0]           char_code;
  logic [PATTERN_W-1:0] beep_bit;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (output start, char_code, input beep_bit, busy, done, err);
  modport slave  (input start, char_code, output beep_bit, busy, done, err);
endinterface

// File: rtl/morse_rom.sv
// Combinational character table: code -> symbol count and dot/dash map.
// sym_o[i] is the i-th symbol sent, 1 = dash.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] code_i,
  output logic       valid_o,
  output logic [2:0] len_o,
  output logic [4:0] sym_o
);

  // Table lookup; out-of-range codes report valid_o = 0.
  always_comb begin
    valid_o = 1'b1;
    len_o   = 3'd0;
    sym_o   = 5'b00000;
    case (code_i)
      CH_A: {len_o, sym_o} = {3'd2, 5'b00010};
      CH_B: {len_o, sym_o} = {3'd4, 5'b00001};
      CH_C: {len_o, sym_o} = {3'd4, 5'b00101};
      CH_D: {len_o, sym_o} = {3'd3, 5'b00001};
      CH_E: {len_o, sym_o} = {3'd1, 5'b00000};
      CH_F: {len_o, sym_o} = {3'd4, 5'b00100};
      CH_G: {len_o, sym_o} = {3'd3, 5'b00011};
      CH_H: {len_o, sym_o} = {3'd4, 5'b00000};
      CH_I: {len_o, sym_o} = {3'd2, 5'b00000};
      CH_J: {len_o, sym_o} = {3'd4, 5'b01110};
      CH_K: {len_o, sym_o} = {3'd3, 5'b00101};
      CH_L: {len_o, sym_o} = {3'd4, 5'b00010};
      CH_M: {len_o, sym_o} = {3'd2, 5'b00011};
      CH_N: {len_o, sym_o} = {3'd2, 5'b00001};
      CH_O: {len_o, sym_o} = {3'd3, 5'b00111};
      CH_P: {len_o, sym_o} = {3'd4, 5'b00110};
      CH_Q: {len_o, sym_o} = {3'd4, 5'b01011};
      CH_R: {len_o, sym_o} = {3'd3, 5'b00010};
      CH_S: {len_o, sym_o} = {3'd3, 5'b00000};
      CH_T: {len_o, sym_o} = {3'd1, 5'b00001};
      CH_U: {len_o, sym_o} = {3'd3, 5'b00100};
      CH_V: {len_o, sym_o} = {3'd4, 5'b01000};
      CH_W: {len_o, sym_o} = {3'd3, 5'b00110};
      CH_X: {len_o, sym_o} = {3'd4, 5'b01001};
      CH_Y: {len_o, sym_o} = {3'd4, 5'b01101};
      CH_Z: {len_o, sym_o} = {3'd4, 5'b00011};
      CH_0: {len_o, sym_o} = {3'd5, 5'b11111};
      CH_1: {len_o, sym_o} = {3'd5, 5'b11110};
      CH_2: {len_o, sym_o} = {3'd5, 5'b11100};
      CH_3: {len_o, sym_o} = {3'd5, 5'b11000};
      CH_4: {len_o, sym_o} = {3'd5, 5'b10000};
      CH_5: {len_o, sym_o} = {3'd5, 5'b00000};
      CH_6: {len_o, sym_o} = {3'd5, 5'b00001};
      CH_7: {len_o, sym_o} = {3'd5, 5'b00011};
      CH_8: {len_o, sym_o} = {3'd5, 5'b00111};
      CH_9: {len_o, sym_o} = {3'd5, 5'b01111};
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_pattern_gen.sv
// Builds the on/off Morse pattern for one character into a shadow register,
// one bit per clock, then commits it to beep_bit in a single edge.
module morse_pattern_gen
  import morse_pkg::*;
#(
  parameter int PATTERN_W = 75,
  parameter int UNIT_BITS = 2
) (
  input logic               clk,
  input logic               rst,
  morse_pattern_gen_if.slave bus
);

  localparam int PTR_W = $clog2(PATTERN_W + 1);
  localparam int UC_W  = $clog2(UNIT_BITS + 1);

  state_e               state_q, state_d;
  logic                 rom_valid_s;
  logic [2:0]           rom_len_s;
  logic [4:0]           rom_sym_s;
  logic [2:0]           len_q;
  logic [4:0]           sym_q;
  logic [2:0]           sym_idx_q;
  logic [UC_W-1:0]      unit_cnt_q;
  logic [1:0]           elem_cnt_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [PATTERN_W-1:0] shadow_q;
  logic [PATTERN_W-1:0] beep_q;
  logic                 busy_q, done_q, err_q;
  logic                 accept_s, reject_s, emit_s, wr_val_s, commit_s;
  logic [1:0]           elem_units_s;
  logic                 unit_last_s, elem_last_s, sym_last_s;

  morse_rom u_rom (
    .code_i  (bus.char_code),
    .valid_o (rom_valid_s),
    .len_o   (rom_len_s),
    .sym_o   (rom_sym_s)
  );

  // Element-end detection: gaps and dots/dashes share the unit/element counters.
  always_comb begin
    elem_units_s = 2'(DOT_UNITS);
    if (state_q == ST_EMIT_GAP) begin
      elem_units_s = 2'(GAP_UNITS);
    end else if (sym_q[sym_idx_q]) begin
      elem_units_s = 2'(DASH_UNITS);
    end else begin
      elem_units_s = 2'(DOT_UNITS);
    end
    unit_last_s = (unit_cnt_q == UC_W'(UNIT_BITS - 1));
    elem_last_s = unit_last_s && (elem_cnt_q == (elem_units_s - 2'd1));
    sym_last_s  = (sym_idx_q == (len_q - 3'd1));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && rom_valid_s) begin
          state_d = ST_EMIT_ON;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT_ON: begin
        if (elem_last_s) begin
          state_d = sym_last_s ? ST_COMMIT : ST_EMIT_GAP;
        end else begin
          state_d = ST_EMIT_ON;
        end
      end
      ST_EMIT_GAP: begin
        if (elem_last_s) begin
          state_d = ST_EMIT_ON;
        end else begin
          state_d = ST_EMIT_GAP;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM output strobes driving the datapath.
  always_comb begin
    accept_s = 1'b0;
    reject_s = 1'b0;
    emit_s   = 1'b0;
    wr_val_s = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept_s = bus.start && rom_valid_s;
        reject_s = bus.start && !rom_valid_s;
      end
      ST_EMIT_ON: begin
        emit_s   = 1'b1;
        wr_val_s = 1'b1;
      end
      ST_EMIT_GAP: emit_s   = 1'b1;
      ST_COMMIT:   commit_s = 1'b1;
      default:     emit_s   = 1'b0;
    endcase
  end

  // Datapath: latch request, serial shadow writes, atomic commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= 3'd0;
      sym_q      <= 5'd0;
      sym_idx_q  <= 3'd0;
      unit_cnt_q <= '0;
      elem_cnt_q <= 2'd0;
      ptr_q      <= '0;
      shadow_q   <= '0;
      beep_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q  <= reject_s;
      done_q <= commit_s;
      if (accept_s) begin
        len_q      <= rom_len_s;
        sym_q      <= rom_sym_s;
        sym_idx_q  <= 3'd0;
        unit_cnt_q <= '0;
        elem_cnt_q <= 2'd0;
        ptr_q      <= '0;
        shadow_q   <= '0;
        busy_q     <= 1'b1;
      end else if (emit_s) begin
        // Writes past the top of the pattern are dropped; sequencing continues.
        if (ptr_q < PTR_W'(PATTERN_W)) begin
          shadow_q[ptr_q] <= wr_val_s;
          ptr_q           <= ptr_q + PTR_W'(1);
        end else begin
          ptr_q <= ptr_q;
        end
        unit_cnt_q <= unit_last_s ? '0 : unit_cnt_q + UC_W'(1);
        if (elem_last_s) begin
          elem_cnt_q <= 2'd0;
        end else if (unit_last_s) begin
          elem_cnt_q <= elem_cnt_q + 2'd1;
        end else begin
          elem_cnt_q <= elem_cnt_q;
        end
        if (elem_last_s && (state_q == ST_EMIT_GAP)) begin
          sym_idx_q <= sym_idx_q + 3'd1;
        end else begin
          sym_idx_q <= sym_idx_q;
        end
      end else if (commit_s) begin
        beep_q <= shadow_q;
        busy_q <= 1'b0;
      end else begin
        busy_q <= busy_q;
      end
    end
  end

  assign bus.beep_bit = beep_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_morse_pattern_gen.sv
// Randomised self-checking bench for morse_pattern_gen; expected patterns come
// from dot/dash strings expanded with the unit timing rules.
module tb_morse_pattern_gen;

  localparam int PW = 75;
  localparam int UB = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  morse_pattern_gen_if #(.PATTERN_W(PW)) bus ();

  morse_pattern_gen #(.PATTERN_W(PW), .UNIT_BITS(UB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  string morse_tab [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----."
  };

  function automatic logic [PW-1:0] model_pattern(input int code, output int n);
    logic [PW-1:0] p;
    int pos;
    int units;
    string s;
    p   = '0;
    pos = 0;
    s   = morse_tab[code];
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) pos += UB;
      units = (s[i] == "-") ? 3 : 1;
      for (int b = 0; b < units * UB; b++) begin
        p[pos] = 1'b1;
        pos++;
      end
    end
    n = pos;
    return p;
  endfunction

  task automatic run_char(input logic [5:0] code, output int lat, output int busy_cyc,
                          output bit timed_out);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.char_code = code;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat       = 0;
    busy_cyc  = bus.busy ? 1 : 0;
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.char_code = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.beep_bit !== '0) begin failures++; $display("FAIL reset_beep got=%h exp=0", bus.beep_bit); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_e();
    int lat, bc, n;
    bit to;
    logic [PW-1:0] exp;
    exp = model_pattern(4, n);
    run_char(6'd4, lat, bc, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL e_timeout got=%b exp=0", to); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL e_latency got=%0d exp=3", lat); end
    checks++; if (bc !== 3) begin failures++; $display("FAIL e_busy_cycles got=%0d exp=3", bc); end
    checks++; if (bus.beep_bit !== 75'h3) begin failures++; $display("FAIL e_const got=%h exp=3", bus.beep_bit); end
    checks++; if (bus.beep_bit !== exp) begin failures++; $display("FAIL e_model got=%h exp=%h", bus.beep_bit, exp); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL e_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_a();
    int lat, bc, n;
    bit to;
    logic [PW-1:0] exp;
    exp = model_pattern(0, n);
    run_char(6'd0, lat, bc, to);
    checks++; if (lat !== n + 1) begin failures++; $display("FAIL a_latency got=%0d exp=%0d", lat, n + 1); end
    checks++; if (lat !== 11) begin failures++; $display("FAIL a_latency_const got=%0d exp=11", lat); end
    checks++; if (bus.beep_bit !== 75'h3F3) begin failures++; $display("FAIL a_const got=%h exp=3f3", bus.beep_bit); end
    checks++; if (bus.beep_bit !== exp) begin failures++; $display("FAIL a_model got=%h exp=%h", bus.beep_bit, exp); end
  endtask

  task automatic test_invalid();
    logic [5:0] code;
    for (int k = 0; k < 3; k++) begin
      code = (k == 0) ? 6'd36 : 6'($urandom_range(36, 63));
      @(negedge clk);
      bus.start     = 1'b1;
      bus.char_code = code;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL inv_err code=%0d got=%b exp=1", code, bus.err); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL inv_busy code=%0d got=%b exp=0", code, bus.busy); end
      @(posedge clk); #1;
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL inv_err_pulse got=%b exp=0", bus.err); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL inv_busy2 got=%b exp=0", bus.busy); end
      checks++; if (bus.beep_bit !== 75'h3F3) begin failures++; $display("FAIL inv_hold got=%h exp=3f3", bus.beep_bit); end
    end
  endtask

  task automatic test_zero();
    int lat, bc, n;
    bit to;
    logic [PW-1:0] exp;
    exp = model_pattern(26, n);
    run_char(6'd26, lat, bc, to);
    checks++; if (lat !== 39) begin failures++; $display("FAIL zero_latency got=%0d exp=39", lat); end
    checks++; if (bc !== n + 1) begin failures++; $display("FAIL zero_busy got=%0d exp=%0d", bc, n + 1); end
    checks++; if (bus.beep_bit !== 75'h3F3F3F3F3F) begin failures++; $display("FAIL zero_const got=%h exp=3f3f3f3f3f", bus.beep_bit); end
    checks++; if (bus.beep_bit !== exp) begin failures++; $display("FAIL zero_model got=%h exp=%h", bus.beep_bit, exp); end
  endtask

  task automatic test_ignore_busy();
    int cyc, extra_done;
    bit got_done;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.char_code = 6'd19;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc      = 0;
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.start     = (i == 2);
      bus.char_code = 6'd4;
      @(posedge clk); #1;
      cyc++;
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    checks++; if (got_done !== 1'b1) begin failures++; $display("FAIL ign_timeout got=%b exp=1", got_done); end
    checks++; if (cyc !== 7) begin failures++; $display("FAIL ign_latency got=%0d exp=7", cyc); end
    checks++; if (bus.beep_bit !== 75'h3F) begin failures++; $display("FAIL ign_pattern got=%h exp=3f", bus.beep_bit); end
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) extra_done++;
    end
    checks++; if (extra_done !== 0) begin failures++; $display("FAIL ign_no_queue got=%0d exp=0", extra_done); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    bit to;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.char_code = 6'd26;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.beep_bit !== '0) begin failures++; $display("FAIL rmid_beep got=%h exp=0", bus.beep_bit); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    run_char(6'd4, lat, bc, to);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rmid_latency got=%0d exp=3", lat); end
    checks++; if (bus.beep_bit !== 75'h3) begin failures++; $display("FAIL rmid_pattern got=%h exp=3", bus.beep_bit); end
  endtask

  task automatic test_random();
    int lat, bc, n, code;
    bit to;
    logic [PW-1:0] exp;
    for (int k = 0; k < 16; k++) begin
      code = $urandom_range(0, 35);
      exp  = model_pattern(code, n);
      run_char(6'(code), lat, bc, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL rnd_timeout code=%0d got=%b exp=0", code, to); end
      checks++; if (lat !== n + 1) begin failures++; $display("FAIL rnd_latency code=%0d got=%0d exp=%0d", code, lat, n + 1); end
      checks++; if (bc !== n + 1) begin failures++; $display("FAIL rnd_busy code=%0d got=%0d exp=%0d", code, bc, n + 1); end
      checks++; if (bus.beep_bit !== exp) begin failures++; $display("FAIL rnd_pattern code=%0d got=%h exp=%h", code, bus.beep_bit, exp); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, n1, n2, c1, c2;
    bit to;
    logic [PW-1:0] e1, e2;
    c1 = $urandom_range(0, 35);
    c2 = $urandom_range(0, 35);
    e1 = model_pattern(c1, n1);
    e2 = model_pattern(c2, n2);
    run_char(6'(c1), lat, bc, to);
    checks++; if (bus.beep_bit !== e1) begin failures++; $display("FAIL b2b_first got=%h exp=%h", bus.beep_bit, e1); end
    run_char(6'(c2), lat, bc, to);
    checks++; if (lat !== n2 + 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, n2 + 1); end
    checks++; if (bus.beep_bit !== e2) begin failures++; $display("FAIL b2b_second got=%h exp=%h", bus.beep_bit, e2); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_e();
    test_a();
    test_invalid();
    test_zero();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_pattern_gen.md
Name: morse_pattern_gen

Overview:
- Converts one character code (A-Z, 0-9) into the Morse on/off bit pattern that the buzzer stage plays, one pattern bit per buzzer step.
- Sits directly upstream of the buzzer; its beep_bit output drives the buzzer's beep_bit input.
- Builds the pattern serially in a shadow register, one bit per clk, then commits it atomically so the buzzer never plays a partial pattern.

Parameters:
- PATTERN_W, 75, width of beep_bit; bit 0 is played first.
- UNIT_BITS, 2, pattern bits per Morse time unit; must satisfy 19*UNIT_BITS <= PATTERN_W.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- char_code  in  6  0-25 = 'A'-'Z', 26-35 = '0'-'9'; 36-63 invalid
- beep_bit  out  PATTERN_W  committed pattern, 1 = tone on
- busy  out  1  high from the edge that accepts start until the commit edge
- done  out  1  one-cycle pulse after commit
- err  out  1  one-cycle pulse when an invalid code is requested

Behaviour:
- Reset state: beep_bit=0, busy=0, done=0, err=0, shadow=0, all counters 0, FSM in IDLE. Reset mid-build discards the build; beep_bit still clears to 0.
- Timing encoding: dot = 1 unit on, dash = 3 units on, intra-character gap = 1 unit off. No leading gap. No trailing gap. Each unit is UNIT_BITS pattern bits.
- ROM: combinational lookup. Output is len[2:0] (1..5) and sym[4:0]. sym[i] is symbol i and is sent i=0 first; 1 = dash.
- Pattern length: N = UNIT_BITS * (sum of symbol units + len - 1). Maximum is digit 0: 19 units.
- IDLE state:
  - start=1 with a valid code: latch len/sym, clear shadow and write pointer, set busy; go to EMIT_ON.
  - start=1 with an invalid code: err=1 for one cycle; beep_bit unchanged; stay in IDLE.
- EMIT_ON state:
  - Each cycle writes 1 to shadow[ptr] and increments ptr.
  - After 1 or 3 units: if it was the last symbol, go to COMMIT; otherwise go to EMIT_GAP.
- EMIT_GAP state: writes 0 for 1 unit, advances symbol index, returns to EMIT_ON.
- COMMIT state: beep_bit <= shadow, busy <= 0, done <= 1 (next cycle only); go to IDLE.
- Latency: start accepted at edge k; bits written at edges k+1..k+N; commit at edge k+N+1. done is high for the cycle after edge k+N+1.
- start while busy is ignored; it is not queued.
- A new start is accepted in the cycle done is high.
- Write pointer saturation: when ptr = PATTERN_W, further writes are dropped. The FSM still completes. This cannot occur within the parameter rule.
- Bits above N in beep_bit are always 0 after commit.

Decomposition:
- Shared package morse_pkg:
  - state encoding (IDLE, EMIT_ON, EMIT_GAP, COMMIT);
  - CODE_MAX=35, DOT_UNITS=1, DASH_UNITS=3, GAP_UNITS=1, MAX_UNITS=19;
  - the char_code enumeration, shared with the decoder path.
- One natural sub-module: morse_rom, the combinational char_code -> {len, sym} table with valid flag.
- Main module: FSM, unit counter, element counter, symbol index, write pointer, shadow register.

Test Plan:
- 'E' (code 4, '.'), UNIT_BITS=2: start at edge k -> done at k+3, beep_bit=0x3, busy high for 3 cycles.
- 'A' (code 0, '.-'): -> N=10, beep_bit=0x3F3, done at k+11.
- '0' (code 26, '-----'): -> N=38, beep_bit bits 0-5, 8-13, 16-21, 24-29, 32-37 set, all others 0, done at k+39.
- char_code=36 with start while idle -> err pulse 1 cycle, busy stays 0, beep_bit holds previous 0x3F3.
- Start 'T' then pulse start with 'E' while busy -> second request ignored; final beep_bit=0x3F ('-' with UNIT_BITS=2) only.
- Assert rst mid-build of '0', then release and request 'E' -> beep_bit=0 and busy=0 immediately on rst; clean 'E' result 0x3 afterwards.
